pulse_stretcher: RTL

//   Turns single-cycle event pulses (e.g. debounced button presses) into clean, human-visible

---
 rtl/pulse_stretcher.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: converts single-cycle event pulses into fixed-length high
// windows, each followed by a fixed low gap. Events that arrive during a
// window or gap are held in a saturating pending counter and replayed one
// after another.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing in progress, out low, waiting for an event
// HIGH  | window in progress, out high for HIGH_COUNT+1 cycles
// GAP   | mandatory low gap of GAP_COUNT+1 cycles after every window
module pulse_stretcher #(
  parameter int COUNT_WIDTH = 20,
  parameter int HIGH_COUNT  = 480000 - 1,
  parameter int GAP_COUNT   = 480000 - 1,
  parameter int PEND_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in,
  output logic                  out,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH:0]  HIGH_LAST = (COUNT_WIDTH + 1)'(HIGH_COUNT);
  localparam logic [COUNT_WIDTH:0]  GAP_LAST  = (COUNT_WIDTH + 1)'(GAP_COUNT);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;

  state_t                  state;
  state_t                  state_nxt;
  logic [COUNT_WIDTH:0]    count;
  logic [COUNT_WIDTH:0]    count_nxt;
  logic [PEND_WIDTH-1:0]   pending_nxt;
  logic                    overflow_nxt;
  logic                    queue_evt;

  // Next-state, counter and pending-queue decisions for the coming cycle.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count + 1'b1;
    pending_nxt  = pending;
    overflow_nxt = 1'b0;
    queue_evt    = 1'b0;

    case (state)
      IDLE: begin
        count_nxt = '0;
        if (in) begin
          state_nxt = HIGH;
        end
      end

      HIGH: begin
        queue_evt = in;
        if (count == HIGH_LAST) begin
          state_nxt = GAP;
          count_nxt = '0;
        end
      end

      GAP: begin
        if (count == GAP_LAST) begin
          count_nxt = '0;
          if (pending != '0) begin
            // A new event at the exit cycle replaces the one being consumed,
            // so the queue depth is unchanged and nothing can overflow.
            state_nxt = HIGH;
            if (!in) begin
              pending_nxt = pending - 1'b1;
            end
          end else if (in) begin
            state_nxt = HIGH;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          queue_evt = in;
        end
      end

      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase

    if (queue_evt) begin
      if (pending != PEND_MAX) begin
        pending_nxt = pending + 1'b1;
      end else begin
        overflow_nxt = 1'b1;
      end
    end
  end

  // State, counter and registered outputs; synchronous active-low reset wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      out      <= (state_nxt == HIGH);
      busy     <= (state_nxt != IDLE);
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule
